adder_share_arbiter: RTL and testbench

Round-robin scheduler that lets four requesters share one eight_bit_adder instance. It latches the winning requester's operands, drives the adder, waits a fixed adder latency, captures sum/cout and returns the result with a one-cycle done pulse to the owner. It sits between client blocks and the single adder datapath.

---
 rtl/adder_share_arbiter.sv | 130 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Purpose  : Round-robin sharing of one external adder among four requesters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [3:0]         cin_in,
  output logic [3:0]         grant,
  output logic [3:0]         done,
  output logic [WIDTH-1:0]   sum_out,
  output logic               cout_out,
  output logic               busy,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int            CW    = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [CW-1:0] c_lat = CW'(ADD_LAT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_ptr, w_ptr;
  logic [1:0]       r_idx, w_idx;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [3:0]       w_grant, w_done;
  logic [WIDTH-1:0] w_a, w_b, w_sum;
  logic             w_cin, w_cout;
  logic [3:0]       w_rot;
  logic [1:0]       w_off, w_pick;
  logic             w_found;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign w_rot = 4'({req, req} >> r_ptr);

  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
    w_found = |req;
    w_pick  = r_ptr + w_off;
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_grant = 4'b0000;
    w_done  = 4'b0000;
    w_a     = add_a;
    w_b     = add_b;
    w_cin   = add_cin;
    w_sum   = sum_out;
    w_cout  = cout_out;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_a     = a_in[w_pick*WIDTH +: WIDTH];
          w_b     = b_in[w_pick*WIDTH +: WIDTH];
          w_cin   = cin_in[w_pick];
          w_grant = 4'b0001 << w_pick;
          w_idx   = w_pick;
          w_cnt   = c_lat;
          w_state = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_sum   = add_sum;
          w_cout  = add_cout;
          w_done  = 4'b0001 << r_idx;
          w_ptr   = r_idx + 2'd1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= 2'd0;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      grant    <= 4'b0000;
      done     <= 4'b0000;
      sum_out  <= '0;
      cout_out <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      grant    <= w_grant;
      done     <= w_done;
      sum_out  <= w_sum;
      cout_out <= w_cout;
      add_a    <= w_a;
      add_b    <= w_b;
      add_cin  <= w_cin;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arbiter
// Purpose  : Scoreboard bench for adder_share_arbiter, ADD_LAT=1 and ADD_LAT=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

  localparam int W = 8;

  typedef struct {
    int         idx;
    logic       cout;
    logic [W-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u1: registered adder (ADD_LAT=1); u0: combinational adder (ADD_LAT=0)
  logic [3:0]   req1, cin1, grant1, done1, req0, cin0, grant0, done0;
  logic [4*W-1:0] a1, b1, a0, b0;
  logic [W-1:0] sum1, add_a1, add_b1, add_sum1, sum0, add_a0, add_b0, add_sum0;
  logic         cout1, busy1, add_cin1, add_cout1, cout0, busy0, add_cin0, add_cout0;

  adder_share_arbiter #(.WIDTH(W), .ADD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .a_in(a1), .b_in(b1), .cin_in(cin1),
    .grant(grant1), .done(done1), .sum_out(sum1), .cout_out(cout1), .busy(busy1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1));

  adder_share_arbiter #(.WIDTH(W), .ADD_LAT(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .a_in(a0), .b_in(b0), .cin_in(cin0),
    .grant(grant0), .done(done0), .sum_out(sum0), .cout_out(cout0), .busy(busy0),
    .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
    .add_sum(add_sum0), .add_cout(add_cout0));

  always @(posedge clk) {add_cout1, add_sum1} <= add_a1 + add_b1 + add_cin1;
  assign {add_cout0, add_sum0} = add_a0 + add_b0 + add_cin0;

  int   nvec = 0;
  int   errs = 0;
  int   gq1[$], gq0[$];
  exp_t dq1[$], dq0[$];
  int   g1, g0;
  exp_t e1, e0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop expected grant owner / result whenever a pulse appears.
  always @(negedge clk) begin
    if (grant1 != 4'b0) begin
      if (gq1.size() == 0) chk("u1 unexpected grant", 32'(grant1), 0);
      else begin g1 = gq1.pop_front(); chk("u1 grant", 32'(grant1), 32'(4'b0001 << g1)); end
    end
    if (done1 != 4'b0) begin
      if (dq1.size() == 0) chk("u1 unexpected done", 32'(done1), 0);
      else begin
        e1 = dq1.pop_front();
        chk("u1 done", 32'(done1), 32'(4'b0001 << e1.idx));
        chk("u1 sum", 32'(sum1), 32'(e1.sum));
        chk("u1 cout", 32'(cout1), 32'(e1.cout));
      end
    end
  end

  always @(negedge clk) begin
    if (grant0 != 4'b0) begin
      if (gq0.size() == 0) chk("u0 unexpected grant", 32'(grant0), 0);
      else begin g0 = gq0.pop_front(); chk("u0 grant", 32'(grant0), 32'(4'b0001 << g0)); end
    end
    if (done0 != 4'b0) begin
      if (dq0.size() == 0) chk("u0 unexpected done", 32'(done0), 0);
      else begin
        e0 = dq0.pop_front();
        chk("u0 done", 32'(done0), 32'(4'b0001 << e0.idx));
        chk("u0 sum", 32'(sum0), 32'(e0.sum));
        chk("u0 cout", 32'(cout0), 32'(e0.cout));
      end
    end
  end

  task automatic setop(input bit s, input int i, input int a, input int b, input bit c);
    if (s) begin a0[i*W +: W] = W'(a); b0[i*W +: W] = W'(b); cin0[i] = c; end
    else   begin a1[i*W +: W] = W'(a); b1[i*W +: W] = W'(b); cin1[i] = c; end
  endtask

  task automatic expect_op(input bit s, input int i, input int cout, input int sum);
    exp_t e;
    e.idx = i; e.cout = cout[0]; e.sum = W'(sum);
    if (s) begin gq0.push_back(i); dq0.push_back(e); end
    else   begin gq1.push_back(i); dq1.push_back(e); end
  endtask

  // Counts edges from the request-sampling edge; c=1 is that edge.
  task automatic run(input bit s, input int ndone, input bit drop, output int first, output int last);
    int k = 0;
    first = -1; last = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); @(negedge clk);
      if (drop && (s ? grant0 != 4'b0 : grant1 != 4'b0)) begin
        if (s) req0 = 4'b0; else req1 = 4'b0;
      end
      if (s ? done0 != 4'b0 : done1 != 4'b0) begin
        k++;
        if (k == 1) first = c;
        if (k == ndone) begin
          last = c;
          if (s) req0 = 4'b0; else req1 = 4'b0;
          break;
        end
      end
    end
    if (k < ndone) chk("timeout waiting for done", 32'(k), 32'(ndone));
  endtask

  int first, last;
  bit seen;

  initial begin
    rst = 1'b1;
    req1 = '0; cin1 = '0; a1 = '0; b1 = '0;
    req0 = '0; cin0 = '0; a0 = '0; b0 = '0;
    repeat (2) @(negedge clk);
    chk("reset grant", 32'(grant1), 0);
    chk("reset done", 32'(done1), 0);
    chk("reset sum", 32'(sum1), 0);
    chk("reset cout", 32'(cout1), 0);
    chk("reset busy", 32'(busy1), 0);
    chk("reset add_a", 32'(add_a1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single op, requester drops req right after grant.
    setop(0, 0, 32, 32, 0); expect_op(0, 0, 0, 64); req1 = 4'b0001;
    run(0, 1, 1, first, last);
    chk("lat1 done latency", 32'(first), 3);

    setop(0, 2, 200, 200, 0); expect_op(0, 2, 1, 144); req1 = 4'b0100;
    run(0, 1, 1, first, last);
    setop(0, 1, 255, 0, 1); expect_op(0, 1, 1, 0); req1 = 4'b0010;
    run(0, 1, 1, first, last);

    // Pointer now at 2: 2 is served before 0.
    setop(0, 0, 1, 2, 0); setop(0, 2, 10, 20, 0);
    expect_op(0, 2, 0, 30); expect_op(0, 0, 0, 3); req1 = 4'b0101;
    run(0, 2, 0, first, last);

    // All four held; pointer at 1 after serving 0.
    setop(0, 0, 10, 100, 0); setop(0, 1, 20, 150, 1);
    setop(0, 2, 30, 200, 0); setop(0, 3, 40, 250, 1);
    expect_op(0, 1, 0, 171); expect_op(0, 2, 0, 230); expect_op(0, 3, 1, 35);
    expect_op(0, 0, 0, 110); expect_op(0, 1, 0, 171); expect_op(0, 2, 0, 230);
    req1 = 4'b1111;
    run(0, 6, 0, first, last);
    chk("rr first done", 32'(first), 3);
    chk("rr sixth done (throughput)", 32'(last), 18);

    // Reset one cycle after grant[3]: operation aborted, no done.
    setop(0, 3, 7, 8, 0); gq1.push_back(3); req1 = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (grant1 != 4'b0) seen = 1'b1;
    end
    chk("grant3 observed", 32'(seen), 1);
    req1 = 4'b0;
    @(posedge clk); #1 rst = 1'b1; #1;
    chk("abort grant", 32'(grant1), 0);
    chk("abort done", 32'(done1), 0);
    chk("abort busy", 32'(busy1), 0);
    chk("abort sum", 32'(sum1), 0);
    chk("abort cout", 32'(cout1), 0);
    chk("abort add_a", 32'(add_a1), 0);
    setop(0, 1, 5, 6, 0); req1 = 4'b0010;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_op(0, 1, 0, 11);
    run(0, 1, 1, first, last);
    chk("post-reset latency", 32'(first), 3);

    // Combinational adder variant.
    setop(1, 0, 20, 20, 0); expect_op(1, 0, 0, 40); req0 = 4'b0001;
    run(1, 1, 1, first, last);
    chk("lat0 done latency", 32'(first), 2);
    setop(1, 3, 100, 156, 1); expect_op(1, 3, 1, 1); req0 = 4'b1000;
    run(1, 1, 1, first, last);
    chk("lat0 carry latency", 32'(first), 2);

    repeat (4) @(negedge clk);
    chk("u1 grants outstanding", 32'(gq1.size()), 0);
    chk("u1 results outstanding", 32'(dq1.size()), 0);
    chk("u0 grants outstanding", 32'(gq0.size()), 0);
    chk("u0 results outstanding", 32'(dq0.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
